// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared format codes, FSM states and RV32I field positions for the encoder
package enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Field LSB positions, identical to those used by dec
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/enc_fmt.sv
// rtl/enc_fmt.sv - combinational RV32I field-to-word packer with legality check
module enc_fmt
    import enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o = 32'b0;
        illegal_o = 1'b0;
        word_o[OPCODE_LSB +: 7] = opcode_i;
        case (fmt_i)
            FMT_R: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[FUNCT7_LSB +: 7] = funct7_i;
            end
            FMT_I: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[31:20]           = imm_i[11:0];
            end
            FMT_S: begin
                word_o[11:7]            = imm_i[4:0];
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[31:25]           = imm_i[11:5];
            end
            FMT_B: begin
                word_o[7]               = imm_i[11];
                word_o[11:8]            = imm_i[4:1];
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[30:25]           = imm_i[10:5];
                word_o[31]              = imm_i[12];
                illegal_o               = imm_i[0];
            end
            FMT_U: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[31:12]           = imm_i[31:12];
            end
            FMT_J: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[19:12]           = imm_i[19:12];
                word_o[20]              = imm_i[11];
                word_o[30:21]           = imm_i[10:1];
                word_o[31]              = imm_i[20];
                // Branch/jump targets are halfword aligned; an odd offset cannot be encoded
                illegal_o               = imm_i[0];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/enc_wr.sv
// rtl/enc_wr.sv - handshaked RV32I encoder writing words to consecutive instruction-memory addresses
module enc_wr
    import enc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     count_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic                full_q;
    logic                err_q;

    logic [31:0]         word;
    logic                illegal;
    logic                last_addr;
    logic                accept;

    enc_fmt u_fmt (
        .fmt_i     (i_fmt),
        .opcode_i  (i_opcode),
        .funct3_i  (i_funct3),
        .funct7_i  (i_funct7),
        .rd_i      (i_rd),
        .rs1_i     (i_rs1),
        .rs2_i     (i_rs2),
        .imm_i     (i_imm),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign last_addr = (addr_q == {ADDR_W{1'b1}});
    assign o_ready   = ((state_q == ST_IDLE) |
                        ((state_q == ST_WRITE) & i_mem_ack & ~last_addr)) & ~i_start;
    assign accept    = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (i_start) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            wdata_q <= word;
                            we_q    <= 1'b1;
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        count_q <= count_q + (ADDR_W+1)'(1);
                        if (last_addr) begin
                            // Address stays on the last word; only a restart rewinds it
                            state_q <= ST_FULL;
                            we_q    <= 1'b0;
                            full_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (accept && !illegal) begin
                                wdata_q <= word;
                            end else begin
                                we_q    <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                            if (accept && illegal) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    state_q <= ST_FULL;
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_enc_wr.sv
// tb/tb_enc_wr.sv - directed table and randomized model-checked bench for enc_wr
module tb_enc_wr;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [2:0]        i_fmt = '0;
    logic [6:0]        i_opcode = '0;
    logic [2:0]        i_funct3 = '0;
    logic [6:0]        i_funct7 = '0;
    logic [4:0]        i_rd = '0;
    logic [4:0]        i_rs1 = '0;
    logic [4:0]        i_rs2 = '0;
    logic [31:0]       i_imm = '0;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ack = 1'b0;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_err;

    int errors = 0;
    int checks = 0;

    enc_wr #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_fmt       (i_fmt),
        .i_opcode    (i_opcode),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_imm       (i_imm),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input vec_t v);
        i_fmt = v.fmt; i_opcode = v.op; i_funct3 = v.f3; i_funct7 = v.f7;
        i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    // Reference encoder built from bit arithmetic on the format rules
    function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] base;
        base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (fmt)
            3'd0: return base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: return base | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
            3'd2: return base | (32'(rs2) << 20) | ((imm & 32'h1F) << 7) |
                         (((imm >> 5) & 32'h7F) << 25);
            3'd3: return base | (32'(rs2) << 20) | (((imm >> 11) & 32'h1) << 7) |
                         (((imm >> 1) & 32'hF) << 8) | (((imm >> 5) & 32'h3F) << 25) |
                         (((imm >> 12) & 32'h1) << 31);
            3'd4: return 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
            default: return 32'(op) | (32'(rd) << 7) | (imm & 32'h000FF000) |
                            (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
                            (((imm >> 20) & 32'h1) << 31);
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [2:0] fmt, input logic [31:0] imm);
        return (fmt > 3'd5) || ((fmt == 3'd3 || fmt == 3'd5) && imm[0]);
    endfunction

    vec_t va, vr, vs, vb;
    bit   m_pend, m_full, m_err, m_ready;
    int   m_count;
    logic [31:0] m_word;

    initial begin
        //            fmt   op      f3    f7    rd     rs1    rs2    imm            word          err
        vecs[0] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0};
        vecs[1] = '{3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3, 1'b0};
        vecs[2] = '{3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0};
        vecs[3] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0};
        vecs[4] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0};
        vecs[5] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0};
        vecs[6] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3,         32'h0,        1'b1};
        vecs[7] = '{3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,         32'h0,        1'b1};
        va = vecs[0]; vr = vecs[1]; vs = vecs[2]; vb = vecs[3];

        // Reset values
        #12;
        chk("rst we", 32'(o_mem_we), 32'd0);
        chk("rst addr", 32'(o_mem_addr), 32'd0);
        chk("rst wdata", o_mem_wdata, 32'd0);
        chk("rst count", 32'(o_count), 32'd0);
        chk("rst full", 32'(o_full), 32'd0);
        chk("rst err", 32'(o_err), 32'd0);
        chk("rst ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Table: each vector written alone with zero-wait memory
        for (int k = 0; k < 8; k++) begin
            do_start();
            i_mem_ack = 1'b1;
            set_fields(vecs[k]);
            i_valid = 1'b1;
            @(negedge i_clk);
            chk($sformatf("v%0d ready", k), 32'(o_ready), 32'd1);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            @(negedge i_clk);
            if (vecs[k].exp_err) begin
                chk($sformatf("v%0d err", k), 32'(o_err), 32'd1);
                chk($sformatf("v%0d no we", k), 32'(o_mem_we), 32'd0);
            end else begin
                chk($sformatf("v%0d we", k), 32'(o_mem_we), 32'd1);
                chk($sformatf("v%0d addr", k), 32'(o_mem_addr), 32'd0);
                chk($sformatf("v%0d wdata", k), o_mem_wdata, vecs[k].exp_word);
            end
            @(posedge i_clk); #1;
            @(negedge i_clk);
            chk($sformatf("v%0d count", k), 32'(o_count), vecs[k].exp_err ? 32'd0 : 32'd1);
            chk($sformatf("v%0d idle we", k), 32'(o_mem_we), 32'd0);
        end

        // Back-to-back R then S with ack held high
        do_start();
        i_mem_ack = 1'b1;
        set_fields(vr); i_valid = 1'b1;
        @(posedge i_clk); #1;
        set_fields(vs);
        @(negedge i_clk);
        chk("b2b w0 addr", 32'(o_mem_addr), 32'd0);
        chk("b2b w0 data", o_mem_wdata, 32'h002081B3);
        chk("b2b ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("b2b w1 we", 32'(o_mem_we), 32'd1);
        chk("b2b w1 addr", 32'(o_mem_addr), 32'd1);
        chk("b2b w1 data", o_mem_wdata, 32'h0020A423);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("b2b count", 32'(o_count), 32'd2);

        // Wait-stated write: three cycles without ack
        do_start();
        i_mem_ack = 1'b0;
        set_fields(vb); i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge i_clk);
            chk($sformatf("wait%0d we", w), 32'(o_mem_we), 32'd1);
            chk($sformatf("wait%0d addr", w), 32'(o_mem_addr), 32'd0);
            chk($sformatf("wait%0d data", w), o_mem_wdata, 32'hFE000EE3);
            chk($sformatf("wait%0d ready", w), 32'(o_ready), 32'd0);
            @(posedge i_clk); #1;
        end
        i_mem_ack = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("wait count", 32'(o_count), 32'd1);
        chk("wait we", 32'(o_mem_we), 32'd0);

        // Fill the memory, then restart
        do_start();
        i_mem_ack = 1'b1;
        set_fields(va); i_valid = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("full flag", 32'(o_full), 32'd1);
        chk("full ready", 32'(o_ready), 32'd0);
        chk("full count", 32'(o_count), 32'd4);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("full hold count", 32'(o_count), 32'd4);
        chk("full hold we", 32'(o_mem_we), 32'd0);
        i_valid = 1'b0;
        i_start = 1'b1;
        #1;
        chk("start ready", 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("restart count", 32'(o_count), 32'd0);
        chk("restart full", 32'(o_full), 32'd0);
        chk("restart addr", 32'(o_mem_addr), 32'd0);
        i_mem_ack = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("restart write we", 32'(o_mem_we), 32'd1);
        chk("restart write addr", 32'(o_mem_addr), 32'd0);

        // Restart during a stalled write
        i_mem_ack = 1'b1;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("midw we", 32'(o_mem_we), 32'd1);
        chk("midw addr", 32'(o_mem_addr), 32'd1);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("midw start we", 32'(o_mem_we), 32'd0);
        chk("midw start count", 32'(o_count), 32'd0);

        // Asynchronous reset in the middle of a write
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("arst pre we", 32'(o_mem_we), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst we", 32'(o_mem_we), 32'd0);
        chk("arst addr", 32'(o_mem_addr), 32'd0);
        chk("arst wdata", o_mem_wdata, 32'd0);
        chk("arst count", 32'(o_count), 32'd0);
        chk("arst full", 32'(o_full), 32'd0);
        chk("arst err", 32'(o_err), 32'd0);
        chk("arst ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Randomized traffic against the behavioural model
        do_start();
        m_pend = 0; m_full = 0; m_err = 0; m_count = 0; m_word = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_start   = ($urandom_range(0, 39) == 0);
            i_valid   = ($urandom_range(0, 9) < 7);
            i_mem_ack = ($urandom_range(0, 9) < 6);
            i_fmt     = 3'($urandom_range(0, 7));
            i_opcode  = 7'($urandom);
            i_funct3  = 3'($urandom);
            i_funct7  = 7'($urandom);
            i_rd      = 5'($urandom);
            i_rs1     = 5'($urandom);
            i_rs2     = 5'($urandom);
            i_imm     = $urandom;
            if ($urandom_range(0, 3) != 0) i_imm[0] = 1'b0;
            @(negedge i_clk);
            m_ready = !i_start && !m_full && (!m_pend || (i_mem_ack && m_count < CAP - 1));
            chk("rnd ready", 32'(o_ready), 32'(m_ready));
            chk("rnd we", 32'(o_mem_we), 32'(m_pend));
            chk("rnd count", 32'(o_count), 32'(m_count));
            chk("rnd full", 32'(o_full), 32'(m_full));
            chk("rnd err", 32'(o_err), 32'(m_err));
            if (m_pend) begin
                chk("rnd addr", 32'(o_mem_addr), 32'(m_count));
                chk("rnd wdata", o_mem_wdata, m_word);
            end
            if (i_start) begin
                m_pend = 0; m_full = 0; m_err = 0; m_count = 0;
            end else begin
                if (m_pend && i_mem_ack) begin
                    m_pend = 0;
                    m_count++;
                    if (m_count == CAP) m_full = 1;
                end
                if (i_valid && m_ready) begin
                    if (ref_illegal(i_fmt, i_imm)) begin
                        m_err = 1;
                    end else begin
                        m_pend = 1;
                        m_word = ref_enc(i_fmt, i_opcode, i_funct3, i_funct7,
                                         i_rd, i_rs1, i_rs2, i_imm);
                    end
                end
            end
            @(posedge i_clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc_wr.md
# enc_wr

Sequential RV32I instruction encoder and program writer: accepts instruction fields plus a format code over a valid/ready handshake, packs them into a 32-bit instruction word and writes that word to consecutive instruction-memory addresses. It is the field-to-word counterpart of `dec`. It sits between the test/boot loader and the instruction memory write port, and supports wait-stated memory through an acknowledge.

## Interface

Parameters:
- `ADDR_W`, default 10: memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  synchronous restart pulse.
- `i_valid`  in  1  field set valid.
- `o_ready`  out  1  field set accepted when `i_valid & o_ready`.
- `i_fmt`  in  3  format: 0 = R, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J; 6 and 7 are illegal.
- `i_opcode`  in  7  opcode field.
- `i_funct3`  in  3  funct3 field.
- `i_funct7`  in  7  funct7 field.
- `i_rd`, `i_rs1`, `i_rs2`  in  5 each  register fields.
- `i_imm`  in  32  immediate.
- `o_mem_we`  out  1  write request.
- `o_mem_addr`  out  ADDR_W  word address.
- `o_mem_wdata`  out  32  encoded word.
- `i_mem_ack`  in  1  write completed this cycle; only meaningful while `o_mem_we` is high.
- `o_count`  out  ADDR_W+1  words written since reset or restart.
- `o_full`  out  1  memory filled.
- `o_err`  out  1  sticky error.

## Operation

Encoding packs `opcode` into bits [6:0] for every format. The rest of the word is:
- R: funct7 | rs2 | rs1 | funct3 | rd.
- I: imm[11:0] | rs1 | funct3 | rd.
- S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
- B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
- U: imm[31:12] | rd.
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Unused immediate bits are ignored.

Rejected field sets:
- A field set is rejected if `i_fmt` is 6 or 7, or if the format is B or J with `i_imm[0]` = 1.
- A rejected field set is still handshaken (consumed).
- It sets `o_err` and produces no write.
- `o_count` and the address do not change.

State machine:
- IDLE: `o_ready` = 1.
  - Accepting a legal field set registers the word and moves to WRITE.
  - Accepting an illegal field set stays in IDLE.
- WRITE: `o_mem_we` = 1. Address and data are held stable until `i_mem_ack`.
  - On ack, `o_count` and `o_mem_addr` increment.
  - If that write was to address 2^ADDR_W − 1, go to FULL.
  - Otherwise, a legal field set accepted in the same cycle stays in WRITE with the new word.
  - Otherwise, go to IDLE.
- FULL: `o_full` = 1 and `o_ready` = 0. Only `i_start` or reset leaves FULL.

Ready rule:
- `o_ready` = (IDLE | (WRITE & `i_mem_ack` & not last address)) & ~`i_start`.
- `o_ready` is combinational from state and `i_mem_ack`.

Restart (`i_start`) from any state:
- Next state is IDLE.
- Address and `o_count` clear to 0; `o_err` and `o_full` clear.
- A pending write is abandoned, and `o_mem_we` falls the next cycle.
- `i_start` wins over a simultaneous handshake; no transfer occurs because `o_ready` is 0.

Address wraps:
- The address wraps to 0 only via restart. FULL prevents any overwrite.

## Timing

Reset values:
- State is IDLE.
- `o_mem_we` = 0, `o_mem_addr` = 0, `o_mem_wdata` = 0.
- `o_count` = 0, `o_full` = 0, `o_err` = 0.
- `o_ready` = 1 (when `i_start` = 0).

Latency and throughput:
- A field set accepted at edge N raises `o_mem_we` with the encoded word in the cycle after edge N.
- With zero-wait memory (ack in the first WRITE cycle), sustained throughput is one word per cycle.
- Each wait cycle (no ack) stalls the input for one cycle.

Status flags:
- `o_err` rises the cycle after an illegal acceptance.
- `o_full` rises the cycle after the final ack.

Reset mid-write:
- Asserting reset during a write drops `o_mem_we` immediately, because reset is asynchronous.

## Structure

- Package `enc_pkg`:
  - Format constants `FMT_R`..`FMT_J`.
  - State enum (IDLE / WRITE / FULL).
  - Field bit-position constants shared with `dec`.
- Sub-module `enc_fmt`: purely combinational field-to-word packer plus legality check (outputs `word`, `illegal`).
- `enc_wr` holds only the FSM, counter, and registers.

## Test plan

- I-format `addi x1,x0,5`: fmt 1, opcode 0x13, rd 1, imm 5 → write 0x00500093 at address 0; `o_count` = 1.
- Back-to-back with ack tied high:
  - R-format `add x3,x1,x2` (opcode 0x33) → 0x002081B3.
  - S-format `sw x2,8(x1)` (opcode 0x23, funct3 2) → 0x0020A423.
  - Both written on consecutive cycles, at addresses 0 and 1.
- B-format `beq x0,x0,-4` (imm 0xFFFFFFFC, opcode 0x63) → 0xFE000EE3.
  - Hold ack low for 3 cycles: address and data stay stable, `o_ready` = 0, then one write completes.
- Immediate formats and rejection:
  - J-format `jal x1,2048` (opcode 0x6F, rd 1) → 0x001000EF.
  - U-format `lui x5,0x12345` → 0x123452B7.
  - J-format with imm 3 → `o_err` = 1, no write, `o_count` unchanged.
- ADDR_W = 2, four writes:
  - `o_full` = 1 and `o_ready` = 0; a fifth `i_valid` is held off.
  - `i_start` → count 0, address 0, `o_full` = 0; the next write goes to address 0.
- Restart and reset mid-write:
  - `i_start` during WRITE with ack low → `o_mem_we` = 0 the next cycle, `o_count` = 0.
  - Reset asserted asynchronously mid-write → all outputs at reset values before the next edge.
